stream_rr_arbiter: RTL
======================

// Module: stream_rr_arbiter
//
// PURPOSE
// - Shares one valid/ready output stream between G_NUM_SRC input streams.
// - Arbitration is round-robin and packet-granular: a grant holds until the
//   beat with last=1 is accepted.
// - Sits in front of the single-stage FIFOs / downstream consumers, merging
//   several producers onto one channel.
// - Output is fully registered: m_valid_o, m_data_o, m_last_o and m_src_o
//   all come from flops.
//
// PARAMETERS
// G_NUM_SRC    4   number of requesting input streams (>=2)
// G_DATA_SIZE  8   data width per beat
//
// PORTS
// clk_i      in   1                    clock, all logic on rising edge
// rst_i      in   1                    asynchronous, active-high reset
// s_valid_i  in   G_NUM_SRC            per-source beat valid
// s_ready_o  out  G_NUM_SRC            per-source beat accepted
// s_data_i   in   G_NUM_SRC*G_DATA_SIZE  source k data at [k*G_DATA_SIZE +: G_DATA_SIZE]
// s_last_i   in   G_NUM_SRC            per-source end-of-packet marker
// m_valid_o  out  1                    output beat valid
// m_ready_i  in   1                    downstream accepts beat
// m_data_o   out  G_DATA_SIZE          output data
// m_last_o   out  1                    output end-of-packet
// m_src_o    out  $clog2(G_NUM_SRC)    index of the source that produced the beat
//
// BEHAVIOUR
// Reset (asynchronous, immediate)
// - m_valid_o=0, m_data_o=0, m_last_o=0, m_src_o=0, s_ready_o=0.
// - state=IDLE; rr pointer=G_NUM_SRC-1, so source 0 has first priority.
// Output register
// - Loads when a source transfer occurs.
// - m_valid_o falls when m_ready_i=1 and no new load occurs that cycle.
// - While m_valid_o && !m_ready_i, m_data_o, m_last_o and m_src_o are stable.
// State machine
// - IDLE:
//   - s_ready_o = 0.
//   - If any s_valid_i: grant <= first valid index after the rr pointer
//     (wrapping modulo G_NUM_SRC), then go to BUSY.
//   - Arbitration costs 1 cycle.
// - BUSY:
//   - s_ready_o[grant] = !m_valid_o || m_ready_i; all other ready bits are 0.
//   - A transfer (s_valid_i[grant] && s_ready_o[grant]) loads the output
//     register with data/last of the granted source, and m_src_o <= grant.
//   - Transfer with s_last_i[grant]=1: rr pointer <= grant, then go to IDLE.
// Handshake and throughput
// - Full throughput of 1 beat/cycle within a packet when m_ready_i=1.
// - Exactly one bubble on the input side between packets.
// - Non-granted sources are never acknowledged; they must hold valid/data
//   stable until accepted (protocol rule, asserted by the bench).
// Boundary conditions
// - Single-beat packet (last on the first beat): BUSY lasts 1 cycle.
// - Granted source drops valid mid-packet: grant stays held; no other source
//   is served.
// - All sources valid: service order after reset is 0,1,...,N-1,0; no
//   starvation.
// - Output full and m_ready_i=0: s_ready_o=0 and nothing is lost.
// - Reset mid-packet: the beat in flight is dropped and the partial packet is
//   not resumed.
//
// STRUCTURE
// - Package stream_arb_pkg:
//   - state_t enum {IDLE, BUSY}.
//   - function rr_next(req, ptr) returning the next index.
// - Sub-module rr_pick:
//   - Combinational round-robin priority selector.
//   - Inputs req[G_NUM_SRC] and ptr; outputs idx and any.
//   - Reused by other arbiters.
// - Top level holds the FSM, grant/pointer registers, and the output register.
//
// TESTING (G_NUM_SRC=4, G_DATA_SIZE=8; formal properties from the team's
// stream checks on every port pair)
// 1. Reset release, src1 sends 0x11,0x12(last), m_ready_i=1
//    -> m_data 0x11,0x12 on consecutive cycles, m_src_o=1, m_last_o on 0x12.
// 2. All four valid with 1-beat packets 0xA0+k
//    -> output order src0,1,2,3,0; m_src_o matches the data.
// 3. src2 sends 3-beat 0x21..0x23 while src0 is valid; m_ready_i low for 2
//    cycles after 0x22 -> 0x22 held stable, no src0 beat interleaved, then
//    0x23 followed by src0.
// 4. src3 packet granted, src3 valid=0 for 3 cycles mid-packet
//    -> s_ready_o[0..2] stay 0, grant resumes on src3.
// 5. Assert rst_i while m_valid_o=1 mid-packet
//    -> m_valid_o=0 the same cycle; after release, src0 has priority.
// 6. Cover: every source granted; back-to-back packets; m_valid_o &&
//    !m_ready_i for >=2 cycles.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the stream arbiters.
// Round-robin selection is kept here so other arbiters can reuse it.
package stream_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int unsigned MAX_SRC = 32;

  // First requesting index after ptr, wrapping modulo n; ptr itself is last.
  function automatic int unsigned rr_next(
    input logic [MAX_SRC-1:0] req,
    input int unsigned        ptr,
    input int unsigned        n
  );
    int unsigned idx;
    int unsigned c;
    logic        found;
    idx   = ptr;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_SRC; i++) begin
      if (!found && i <= n) begin
        c = (ptr + i) % n;
        if (req[c[4:0]]) begin
          idx   = c;
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector.
// idx is only meaningful while any is high.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int unsigned G_NUM_SRC = 4
) (
  input  logic [G_NUM_SRC-1:0]         req,
  input  logic [$clog2(G_NUM_SRC)-1:0] ptr,
  output logic [$clog2(G_NUM_SRC)-1:0] idx,
  output logic                         any
);

  localparam int unsigned W = $clog2(G_NUM_SRC);

  logic [MAX_SRC-1:0] req_ext;

  always_comb begin
    req_ext                 = '0;
    req_ext[G_NUM_SRC-1:0]  = req;
    idx = W'(rr_next(req_ext, 32'(ptr), G_NUM_SRC));
  end

  assign any = |req;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin merge of several valid/ready streams
// onto one fully registered output stream.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int unsigned G_NUM_SRC   = 4,
  parameter int unsigned G_DATA_SIZE = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [G_NUM_SRC-1:0]             s_valid_i,
  output logic [G_NUM_SRC-1:0]             s_ready_o,
  input  logic [G_NUM_SRC*G_DATA_SIZE-1:0] s_data_i,
  input  logic [G_NUM_SRC-1:0]             s_last_i,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [G_DATA_SIZE-1:0]           m_data_o,
  output logic                             m_last_o,
  output logic [$clog2(G_NUM_SRC)-1:0]     m_src_o
);

  localparam int unsigned SRC_W = $clog2(G_NUM_SRC);

  state_t                 state_q;
  state_t                 state_d;
  logic [SRC_W-1:0]       grant_q;
  logic [SRC_W-1:0]       ptr_q;
  logic [SRC_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [G_DATA_SIZE-1:0] beat_data;
  logic                   beat_last;
  logic                   beat_valid;
  logic                   out_free;
  logic                   xfer;

  rr_pick #(
    .G_NUM_SRC(G_NUM_SRC)
  ) u_pick (
    .req(s_valid_i),
    .ptr(ptr_q),
    .idx(pick_idx),
    .any(pick_any)
  );

  always_comb begin
    beat_data  = '0;
    beat_last  = 1'b0;
    beat_valid = 1'b0;
    for (int unsigned k = 0; k < G_NUM_SRC; k++) begin
      if (grant_q == SRC_W'(k)) begin
        beat_data  = s_data_i[k*G_DATA_SIZE +: G_DATA_SIZE];
        beat_last  = s_last_i[k];
        beat_valid = s_valid_i[k];
      end
    end
  end

  // Output slot can take a beat when empty or draining this cycle.
  assign out_free = !m_valid_o || m_ready_i;
  assign xfer     = (state_q == BUSY) && beat_valid && out_free;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (pick_any) state_d = BUSY;
      BUSY: if (xfer && beat_last) state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready_o = '0;
    if (state_q == BUSY) begin
      for (int unsigned k = 0; k < G_NUM_SRC; k++) begin
        s_ready_o[k] = (grant_q == SRC_W'(k)) && out_free;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q <= '0;
      ptr_q   <= SRC_W'(G_NUM_SRC - 1);
    end else begin
      if (state_q == IDLE && pick_any) grant_q <= pick_idx;
      if (xfer && beat_last) ptr_q <= grant_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
      m_src_o   <= '0;
    end else if (xfer) begin
      m_valid_o <= 1'b1;
      m_data_o  <= beat_data;
      m_last_o  <= beat_last;
      m_src_o   <= grant_q;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule
